// File: rtl/noc_inject_arbiter_pkg.sv
// Shared types and sizing helpers for the injection arbiter; no logic, no latency.
// Packets are opaque to the arbiter and carried through unchanged.
package noc_inject_arbiter_pkg;

    localparam int INJ_REQ_DEFAULT   = 4;
    localparam int INJ_CNT_W_DEFAULT = 16;

    typedef struct packed {
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [7:0]  tag;
        logic [15:0] payload;
    } packet_t;

    // Round-robin pointer width; a single requester still needs one bit.
    function automatic int rr_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Requester and network-port bundle for the injection arbiter; wires only, no latency.
// master drives requests and net_en, slave (the arbiter) returns acks and the network packet.
interface noc_inject_arbiter_if
    import noc_inject_arbiter_pkg::*;
#(
    parameter int REQ = INJ_REQ_DEFAULT
) ();

    logic    [0:REQ-1] req_val;
    packet_t [0:REQ-1] req_data;
    logic    [0:REQ-1] req_ack;
    packet_t           net_data;
    logic              net_val;
    logic              net_en;

    modport master (
        output req_val, req_data, net_en,
        input  req_ack, net_data, net_val
    );

    modport slave (
        input  req_val, req_data, net_en,
        output req_ack, net_data, net_val
    );

endinterface

// File: rtl/noc_inject_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req at or above ptr, wrapping; zero latency.
// No state and no backpressure of its own; callers mask req when they cannot accept.
module rr_arbiter
    import noc_inject_arbiter_pkg::*;
#(
    parameter int N  = INJ_REQ_DEFAULT,
    parameter int PW = rr_ptr_w(N)
) (
    input  logic [0:N-1]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [0:N-1]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    int cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Round-robin injection arbiter into a one-entry output register; ack-to-net_val latency 1 cycle.
// Stalls (no acks) while full and net_en is low; optional grant counters with INJ_ARB_STATS_EN.
module noc_inject_arbiter
    import noc_inject_arbiter_pkg::*;
#(
    parameter int REQ   = INJ_REQ_DEFAULT,
    parameter int CNT_W = INJ_CNT_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    noc_inject_arbiter_if.slave          bus
`ifdef INJ_ARB_STATS_EN
    ,
    output logic [0:REQ-1][CNT_W-1:0]    grant_cnt
`endif
);

    localparam int PW = rr_ptr_w(REQ);

    if (REQ < 1 || CNT_W < 1) begin : g_bad_params
        $error("noc_inject_arbiter: REQ and CNT_W must be at least 1");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    packet_t       data_q, data_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic          can_load;
    logic [0:REQ-1] arb_req;
    logic [0:REQ-1] arb_grant;
    logic [PW-1:0] arb_idx;
    logic          arb_any;
    logic [0:REQ-1] ack;

    // A full register frees up in the same cycle the network takes its packet.
    assign can_load = (state_q == ST_EMPTY) || bus.net_en;
    assign arb_req  = bus.req_val & {REQ{can_load}};

    rr_arbiter #(
        .N  (REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign ack = arb_grant & {REQ{~reset}};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (arb_any) begin
            state_d = ST_FULL;
            data_d  = bus.req_data[arb_idx];
            ptr_d   = (int'(arb_idx) == REQ - 1) ? '0 : arb_idx + PW'(1);
        end else if (state_q == ST_FULL && bus.net_en) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.req_ack  = ack;
    assign bus.net_val  = (state_q == ST_FULL);
    assign bus.net_data = data_q;

`ifdef INJ_ARB_STATS_EN
    logic [0:REQ-1][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < REQ; i++) begin
            if (ack[i] && cnt_q[i] != {CNT_W{1'b1}}) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Per-node injection arbiter that shares a single network input port among `REQ` local packet sources. It sits between a node's local requesters (traffic generators, core interfaces) and the network's per-node `i_data`/`i_data_val`/`o_en` port. It performs round-robin arbitration into a one-entry output register that implements the network's valid/enable protocol. One instance is placed per node, in the FPGA top level, in front of `network`.

## Interface
Parameters:
- `REQ`, default 4: number of local requesters, ≥1.
- `CNT_W`, default 16: width of the per-requester grant counters (stats build only).

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req_val`, in, `[0:REQ-1]`: requester i has a packet.
- `req_data`, in, `packet_t [0:REQ-1]`: requester packets.
- `req_ack`, out, `[0:REQ-1]`: one-hot; requester i's packet is accepted this cycle.
- `net_data`, out, `packet_t`: to network `i_data[node]`.
- `net_val`, out, 1: to network `i_data_val[node]`.
- `net_en`, in, 1: from network `o_en[node]`; network accepts when high.
- `grant_cnt`, out, `[0:REQ-1][CNT_W-1:0]`: per-requester accepted-packet counters. Present only with `INJ_ARB_STATS_EN`.

## Operation
- Output register has two states:
  - EMPTY: `net_val`=0.
  - FULL: `net_val`=1, holding `net_data`.
- Network transfer occurs when `net_val && net_en` in the same cycle.
- The register can load when it is EMPTY, or when it is FULL and a transfer occurs this cycle (pass-through). Call this `can_load`.
- Arbitration:
  - If `can_load` and any `req_val` is set, grant the first set requester searching from `rr_ptr` upward, modulo `REQ`.
  - Assert `req_ack[g]` combinationally in that cycle.
  - Load `req_data[g]` into the register.
  - Next `rr_ptr` = (g+1) mod `REQ`.
- With no grant, `rr_ptr` is unchanged and all `req_ack` are 0.
- State transitions:
  - EMPTY→FULL on grant.
  - FULL→EMPTY on transfer without a grant.
  - FULL→FULL on transfer with a grant (new packet), or on no transfer (hold).
- While FULL and `net_en`=0, `net_data` and `net_val` stay stable. No requester is acked.
- Requesters hold `req_val`/`req_data` stable until acked. Deasserting before ack is allowed; the packet is simply not taken.
- `req_ack` is never asserted for a requester whose `req_val` is 0.
- `REQ`=1 degenerates to a pass-through register; `rr_ptr` stays 0.
- Packet contents are opaque; no field is inspected or modified.

## Timing
- Reset values:
  - `net_val`=0 and `net_data`=0.
  - `req_ack`=0 during reset.
  - `rr_ptr`=0, giving requester 0 first priority.
  - `grant_cnt`=0.
- Latency: packet acked in cycle t appears on `net_val`/`net_data` in cycle t+1.
- Throughput: one packet per cycle when `net_en` is held high.
- `req_ack` depends combinationally on `req_val`, state, `rr_ptr` and `net_en`. There is no combinational path from `req_data` to any output other than through the register.
- `net_val`/`net_data` are registered outputs with no combinational path from inputs.
- Reset asserted mid-operation discards the held packet: `net_val`=0 on the next cycle. A packet acked in the same cycle as reset is dropped, and the requester must not rely on it.

## Configuration
- Macro: `INJ_ARB_STATS_EN`.
- Defined:
  - `grant_cnt` port exists.
  - `grant_cnt[i]` increments by 1 on each cycle `req_ack[i]`=1.
  - It saturates at 2^`CNT_W`−1 and does not wrap.
  - Cleared only by `reset`.
- Undefined: port and counters are absent. Arbitration behaviour is identical.

## Structure
- `packet_t` comes from the shared config package.
- Add `INJ_REQ_DEFAULT` and the `rr_ptr` width helper (`$clog2(REQ)`, minimum 1) to the package.
- One natural sub-module: `rr_arbiter`. It is purely combinational: it takes `req` and `ptr` and returns one-hot `grant` plus an encoded index. It is reusable for router output ports.
- The register/FSM and counters stay in `noc_inject_arbiter`.

## Test plan
- **Reset:** hold `reset` 3 cycles with all `req_val`=1 → `net_val`=0, `req_ack`=0; first grant after release goes to requester 0.
- **Round-robin fairness:** `REQ`=4, all `req_val`=1, `net_en`=1 for 8 cycles → ack order 0,1,2,3,0,1,2,3; `net_val`=1 from cycle 2 onward; each packet appears exactly one cycle after its ack.
- **Backpressure:**
  - Load packet A, then hold `net_en`=0 for 5 cycles with `req_val`=4'b0110 → `net_data`=A stable, no acks.
  - Raise `net_en` → A transfers and requester 1 is acked in the same cycle (pass-through).
- **Sparse/skip:** `req_val`=4'b1001 with `rr_ptr`=1 → requester 3 granted, `rr_ptr` becomes 0; next grant goes to requester 0.
- **Drain:** single packet, `net_en`=1, no further requests → `net_val` high for exactly 1 cycle, then 0; `rr_ptr` unchanged while idle.
- **Stats (`INJ_ARB_STATS_EN`, `CNT_W`=4):** 20 grants to requester 2 → `grant_cnt[2]`=15 (saturated), others 0.
